// File: rtl/puf_ecc_pkg.sv
// Shared definitions for the PUF key-path Hamming(15,11) framer and decoder.
package puf_ecc_pkg;

  localparam int unsigned CW_W   = 15;
  localparam int unsigned DATA_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/puf_codeword_framer.sv
// Frames serial PUF response bits into 15-bit codewords for the Hamming decoder.
// Define PUF_HELPER_XOR_EN to XOR each word with helper_word (code-offset reconstruction).
module puf_codeword_framer
  import puf_ecc_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned IDX_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic [0:CW_W-1]   helper_word,
  output logic [IDX_W-1:0]  helper_idx,
  output logic [0:CW_W-1]   cw_out,
  output logic              cw_valid,
  input  logic              cw_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0]       LAST_BIT  = 4'(CW_W - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_WORDS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [0:CW_W-2]   r_shreg;
  logic [3:0]        r_bit_cnt;
  logic [IDX_W-1:0]  r_word_cnt;
  logic [0:CW_W-1]   r_cw;

  logic              w_bit_acc;
  logic              w_last_bit;
  logic              w_cw_acc;
  logic [0:CW_W-1]   w_raw;
  logic [0:CW_W-1]   w_cw_next;

  assign w_bit_acc  = bit_valid && (r_state == SHIFT);
  assign w_last_bit = w_bit_acc && (r_bit_cnt == LAST_BIT);
  assign w_cw_acc   = (r_state == HOLD) && cw_ready;
  // The 15th bit bypasses the shift register and lands directly in c_h[14].
  assign w_raw      = {r_shreg, bit_in};

`ifdef PUF_HELPER_XOR_EN
  assign w_cw_next = w_raw ^ helper_word;
`else
  logic w_unused_helper;
  assign w_unused_helper = ^helper_word;
  assign w_cw_next       = w_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_cw       <= '0;
    end else begin
      r_state <= w_next;
      if (w_last_bit) begin
        r_cw      <= w_cw_next;
        r_bit_cnt <= '0;
      end else if (w_bit_acc) begin
        r_shreg[r_bit_cnt] <= bit_in;
        r_bit_cnt          <= r_bit_cnt + 4'd1;
      end
      if (r_state == DONE) begin
        r_word_cnt <= '0;
      end else if (w_cw_acc && (r_word_cnt != LAST_WORD)) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    bit_ready = 1'b0;
    cw_valid  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = SHIFT;
      end
      SHIFT: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        if (w_last_bit) w_next = HOLD;
      end
      HOLD: begin
        cw_valid = 1'b1;
        busy     = 1'b1;
        if (cw_ready) w_next = (r_word_cnt == LAST_WORD) ? DONE : SHIFT;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign helper_idx = r_word_cnt;
  assign cw_out     = r_cw;

endmodule

// File: tb/tb_puf_codeword_framer.sv
// Directed self-checking bench for puf_codeword_framer (NUM_WORDS=3).
module tb_puf_codeword_framer;
  import puf_ecc_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic [0:14]   helper_word;
  logic [7:0]    helper_idx;
  logic [0:14]   cw_out;
  logic          cw_valid;
  logic          cw_ready;
  logic          busy;
  logic          done;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned done_cnt = 0;

  logic [14:0] data_tbl   [3];
  logic [14:0] helper_tbl [3];

  puf_codeword_framer #(.NUM_WORDS(3), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .helper_word(helper_word), .helper_idx(helper_idx),
    .cw_out(cw_out), .cw_valid(cw_valid), .cw_ready(cw_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    helper_word = '0;
    if (helper_idx < 8'd3) helper_word = helper_tbl[helper_idx[1:0]];
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] exp_cw(input logic [14:0] d, input logic [14:0] h);
`ifdef PUF_HELPER_XOR_EN
    return d ^ h;
`else
    if (h == 15'h7fff) return d;  // helper unused in this build
    return d;
`endif
  endfunction

  // Feeds one word MSB first (vector index 0 = c_h[0]); optional gaps and a stray start at bit 7.
  task automatic feed_word(input logic [14:0] w, input bit gaps, input bit poke_start);
    logic [0:14] v;
    v = w;
    for (int i = 0; i < 15; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bit_valid = 1'b0;
          bit_in    = ~v[i];
          tick();
        end
      end
      if (i == 14) check("cw_valid_before_last", {31'd0, cw_valid}, 32'd0);
      bit_in    = v[i];
      bit_valid = 1'b1;
      start     = poke_start && (i == 7);
      tick();
      start     = 1'b0;
    end
    bit_valid = 1'b0;
  endtask

  task automatic accept(input int unsigned stall);
    logic [0:14] held;
    held = cw_out;
    cw_ready = 1'b0;
    for (int unsigned k = 0; k < stall; k++) begin
      bit_valid = 1'b1;
      start     = (k == 1);
      tick();
      start     = 1'b0;
      check("hold_stable", {17'd0, cw_out}, {17'd0, held});
      check("hold_bit_ready", {31'd0, bit_ready}, 32'd0);
    end
    bit_valid = 1'b0;
    cw_ready  = 1'b1;
    tick();
    cw_ready  = 1'b0;
    check("valid_drop", {31'd0, cw_valid}, 32'd0);
  endtask

  task automatic run3(input bit gaps, input int unsigned stall_w);
    int unsigned d0;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {30'd0, busy, bit_ready}, 32'd3);
    for (int w = 0; w < 3; w++) begin
      check("helper_idx", {24'd0, helper_idx}, w);
      feed_word(data_tbl[w], gaps, (w == 1));
      check("cw_valid_latency", {31'd0, cw_valid}, 32'd1);
      check("cw_out", {17'd0, cw_out}, {17'd0, exp_cw(data_tbl[w], helper_tbl[w])});
      check("helper_idx_hold", {24'd0, helper_idx}, w);
      accept((w == 1) ? stall_w : 0);
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    start = 1'b1;  // same cycle as done: must be ignored
    tick();
    start = 1'b0;
    check("done_one_cycle", {29'd0, done, busy, bit_ready}, 32'd0);
    tick();
    check("idle_after_done", {30'd0, busy, bit_ready}, 32'd0);
    check("done_count", done_cnt - d0, 32'd1);
    check("idx_cleared", {24'd0, helper_idx}, 32'd0);
  endtask

  initial begin
    data_tbl[0] = 15'h5555; data_tbl[1] = 15'h0000; data_tbl[2] = 15'h1234;
    helper_tbl[0] = 15'h0000; helper_tbl[1] = 15'h7fff; helper_tbl[2] = 15'h0f0f;
    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; cw_ready = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {4'd0, bit_ready, cw_valid, busy, done, helper_idx, 1'b0, cw_out}, 32'd0);
    rst = 1'b0;
    bit_valid = 1'b1;
    tick();
    check("idle_ignores_bits", {30'd0, busy, bit_ready}, 32'd0);
    bit_valid = 1'b0;

    run3(1'b0, 5);
    run3(1'b1, 5);

    // Reset in the middle of word 1.
    start = 1'b1;
    tick();
    start = 1'b0;
    feed_word(data_tbl[0], 1'b0, 1'b0);
    accept(0);
    for (int i = 0; i < 7; i++) begin
      bit_in = 1'b1; bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrun_reset", {4'd0, bit_ready, cw_valid, busy, done, helper_idx, 1'b0, cw_out}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("no_done_on_reset", done_cnt, 32'd2);
    run3(1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
